// File: rtl/mmu_merge_sched_if.sv
// Drive/free pulse handshake bundle between the requester ports, the scheduler and the downstream stage.
// i_join exists only when MMU_SCHED_JOIN_EN is defined.
interface mmu_merge_sched_if #(
  parameter int NUM_PORTS = 3
);
  logic [NUM_PORTS-1:0] i_drive;
  logic [NUM_PORTS-1:0] o_free;
  logic                 o_driveNext;
  logic                 i_freeNext;
  logic [1:0]           o_grant_id;
  logic                 o_busy;
  logic                 o_timeout;
  logic                 o_overflow;
  logic                 o_spurious;
`ifdef MMU_SCHED_JOIN_EN
  logic                 i_join;
`endif

  modport master (
`ifdef MMU_SCHED_JOIN_EN
    output i_join,
`endif
    output i_drive,
    output i_freeNext,
    input  o_free,
    input  o_driveNext,
    input  o_grant_id,
    input  o_busy,
    input  o_timeout,
    input  o_overflow,
    input  o_spurious
  );

  modport slave (
`ifdef MMU_SCHED_JOIN_EN
    input  i_join,
`endif
    input  i_drive,
    input  i_freeNext,
    output o_free,
    output o_driveNext,
    output o_grant_id,
    output o_busy,
    output o_timeout,
    output o_overflow,
    output o_spurious
  );
endinterface

// File: rtl/mmu_merge_sched.sv
// Round-robin scheduler sharing one downstream MMU stage among NUM_PORTS pulse-handshake requesters.
// Optional MMU_SCHED_JOIN_EN adds i_join: wait for every port, issue once, free all ports together.
module mmu_merge_sched #(
  parameter int NUM_PORTS = 3,
  parameter int TO_W      = 8,
  parameter int TIMEOUT   = 200
) (
  input logic          clk,
  input logic          rst,
  mmu_merge_sched_if.slave bus
);
  // state | meaning
  // IDLE  | no grant outstanding, arbitrating among pending ports
  // ISSUE | o_driveNext cycle for the granted port
  // WAIT  | waiting for i_freeNext or timeout expiry
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  localparam logic [TO_W-1:0] TO_VAL   = TO_W'(TIMEOUT);
  localparam logic [1:0]      LAST_RST = 2'(NUM_PORTS - 1);

  state_t               state, state_nxt;
  logic [NUM_PORTS-1:0] pending, pending_nxt;
  logic [NUM_PORTS-1:0] clr_mask, free_nxt;
  logic [1:0]           last, last_nxt;
  logic [1:0]           grant, grant_nxt;
  logic [1:0]           winner;
  logic [TO_W-1:0]      cnt, cnt_nxt;
  logic                 complete;
  logic                 timeout_nxt;
  logic                 overflow_set;
  logic                 spurious_set;
  logic                 join_mode;

`ifdef MMU_SCHED_JOIN_EN
  assign join_mode = bus.i_join;
`else
  assign join_mode = 1'b0;
`endif

  function automatic logic [1:0] rr_idx(input logic [1:0] base, input int off);
    int t;
    t = int'(base) + off;
    if (t >= NUM_PORTS) t = t - NUM_PORTS;
    return 2'(t);
  endfunction

  // Scan from farthest to nearest so the port closest after 'last' is written last and wins.
  always_comb begin
    winner = '0;
    for (int i = NUM_PORTS; i >= 1; i--) begin
      for (int k = 0; k < NUM_PORTS; k++) begin
        if (pending[k] && (rr_idx(last, i) == 2'(k))) winner = 2'(k);
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    grant_nxt   = grant;
    last_nxt    = last;
    cnt_nxt     = cnt;
    complete    = 1'b0;
    timeout_nxt = 1'b0;
    clr_mask    = '0;
    free_nxt    = '0;

    case (state)
      IDLE: begin
        if (join_mode ? (&pending) : (|pending)) begin
          state_nxt = ISSUE;
          grant_nxt = join_mode ? 2'd0 : winner;
          cnt_nxt   = '0;
        end
      end
      ISSUE: begin
        state_nxt = WAIT;
        complete  = bus.i_freeNext;
      end
      WAIT: begin
        cnt_nxt = cnt + 1'b1;
        if (bus.i_freeNext) begin
          complete = 1'b1;
        end else if ((TIMEOUT != 0) && (cnt_nxt == TO_VAL)) begin
          complete    = 1'b1;
          timeout_nxt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (complete) begin
      state_nxt = IDLE;
      for (int k = 0; k < NUM_PORTS; k++) begin
        clr_mask[k] = join_mode || (grant == 2'(k));
      end
      free_nxt = clr_mask;
      if (!join_mode) last_nxt = grant;
    end
  end

  // A drive landing on the completion edge survives the clear as a fresh token.
  assign pending_nxt  = (pending & ~clr_mask) | bus.i_drive;
  assign overflow_set = |(bus.i_drive & pending & ~clr_mask);
  assign spurious_set = (state == IDLE) && bus.i_freeNext;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      pending         <= '0;
      last            <= LAST_RST;
      grant           <= '0;
      cnt             <= '0;
      bus.o_free      <= '0;
      bus.o_driveNext <= 1'b0;
      bus.o_busy      <= 1'b0;
      bus.o_timeout   <= 1'b0;
      bus.o_overflow  <= 1'b0;
      bus.o_spurious  <= 1'b0;
    end else begin
      state           <= state_nxt;
      pending         <= pending_nxt;
      last            <= last_nxt;
      grant           <= grant_nxt;
      cnt             <= cnt_nxt;
      bus.o_free      <= free_nxt;
      bus.o_driveNext <= (state_nxt == ISSUE);
      bus.o_busy      <= (state_nxt != IDLE);
      bus.o_timeout   <= timeout_nxt;
      if (overflow_set) bus.o_overflow <= 1'b1;
      if (spurious_set) bus.o_spurious <= 1'b1;
    end
  end

  assign bus.o_grant_id = grant;

endmodule

// File: tb/tb_mmu_merge_sched.sv
// Directed bench for mmu_merge_sched: inputs change on the falling edge, outputs are checked on falling edges.
module tb_mmu_merge_sched;
  localparam int NP = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  mmu_merge_sched_if #(.NUM_PORTS(NP)) bus();

  mmu_merge_sched #(
    .NUM_PORTS(NP),
    .TO_W     (8),
    .TIMEOUT  (10)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic nxt(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.i_drive    = '0;
    bus.i_freeNext = 1'b0;
`ifdef MMU_SCHED_JOIN_EN
    bus.i_join = 1'b0;
`endif
    nxt(2);
    rst = 1'b0;
    nxt();
  endtask

  // Present a one-cycle drive; returns on the following falling edge.
  task automatic pulse_drive(input logic [2:0] m);
    bus.i_drive = m;
    nxt();
    bus.i_drive = '0;
  endtask

  // Called in the ISSUE cycle; frees one cycle later and returns on the cycle after o_free.
  task automatic serve(input logic [1:0] g, input logic [2:0] m);
    chk("issue", bus.o_driveNext, 1'b1);
    chk("grant", bus.o_grant_id, g);
    nxt();
    chk("issue_one_cycle", bus.o_driveNext, 1'b0);
    bus.i_freeNext = 1'b1;
    nxt();
    bus.i_freeNext = 1'b0;
    chk("free", bus.o_free, m);
    chk("idle_with_free", bus.o_busy, 1'b0);
    nxt();
    chk("free_one_cycle", bus.o_free, 3'b000);
  endtask

  initial begin
    bus.i_drive    = '0;
    bus.i_freeNext = 1'b0;
`ifdef MMU_SCHED_JOIN_EN
    bus.i_join = 1'b0;
`endif
    nxt(2);
    chk("rst_busy", bus.o_busy, 1'b0);
    chk("rst_drivenext", bus.o_driveNext, 1'b0);
    chk("rst_free", bus.o_free, 3'b000);
    chk("rst_grant", bus.o_grant_id, 2'd0);
    chk("rst_timeout", bus.o_timeout, 1'b0);
    chk("rst_overflow", bus.o_overflow, 1'b0);
    chk("rst_spurious", bus.o_spurious, 1'b0);
    rst = 1'b0;
    nxt();

    // single request on port 1
    pulse_drive(3'b010);
    chk("single_not_yet", bus.o_driveNext, 1'b0);
    nxt();
    chk("single_issue", bus.o_driveNext, 1'b1);
    chk("single_grant", bus.o_grant_id, 2'd1);
    chk("single_busy", bus.o_busy, 1'b1);
    nxt(4);
    chk("single_wait_drv", bus.o_driveNext, 1'b0);
    chk("single_wait_busy", bus.o_busy, 1'b1);
    nxt();
    bus.i_freeNext = 1'b1;
    nxt();
    bus.i_freeNext = 1'b0;
    chk("single_free", bus.o_free, 3'b010);
    chk("single_busy_after", bus.o_busy, 1'b0);
    nxt();
    chk("single_free_done", bus.o_free, 3'b000);
    chk("single_idle", bus.o_busy, 1'b0);

    // round robin, 3-cycle issue period
    do_reset();
    pulse_drive(3'b111);
    nxt();
    serve(2'd0, 3'b001);
    serve(2'd1, 3'b010);
    serve(2'd2, 3'b100);
    chk("rr_drained", bus.o_driveNext, 1'b0);
    pulse_drive(3'b101);
    nxt();
    serve(2'd0, 3'b001);
    serve(2'd2, 3'b100);
    chk("rr2_drained", bus.o_driveNext, 1'b0);

    // same-edge re-request, then overflow
    do_reset();
    pulse_drive(3'b001);
    nxt();
    chk("reissue_first", bus.o_driveNext, 1'b1);
    nxt();
    bus.i_drive    = 3'b001;
    bus.i_freeNext = 1'b1;
    nxt();
    bus.i_drive    = '0;
    bus.i_freeNext = 1'b0;
    chk("reissue_free", bus.o_free, 3'b001);
    nxt();
    chk("reissue_overflow", bus.o_overflow, 1'b0);
    serve(2'd0, 3'b001);
    pulse_drive(3'b001);
    nxt();
    chk("ovf_issue", bus.o_driveNext, 1'b1);
    nxt();
    bus.i_drive = 3'b001;
    nxt();
    bus.i_drive = '0;
    chk("ovf_set", bus.o_overflow, 1'b1);
    nxt();
    bus.i_drive = 3'b001;
    nxt();
    bus.i_drive    = '0;
    bus.i_freeNext = 1'b1;
    nxt();
    bus.i_freeNext = 1'b0;
    chk("ovf_free", bus.o_free, 3'b001);
    nxt();
    chk("ovf_once_drv", bus.o_driveNext, 1'b0);
    nxt();
    chk("ovf_once_drv2", bus.o_driveNext, 1'b0);
    chk("ovf_once_busy", bus.o_busy, 1'b0);
    chk("ovf_sticky", bus.o_overflow, 1'b1);

    // timeout after 11 cycles, then free on the expiry edge
    do_reset();
    pulse_drive(3'b100);
    nxt();
    chk("to_issue", bus.o_driveNext, 1'b1);
    chk("to_grant", bus.o_grant_id, 2'd2);
    nxt(10);
    chk("to_early_free", bus.o_free, 3'b000);
    chk("to_early_flag", bus.o_timeout, 1'b0);
    chk("to_early_busy", bus.o_busy, 1'b1);
    nxt();
    chk("to_flag", bus.o_timeout, 1'b1);
    chk("to_free", bus.o_free, 3'b100);
    chk("to_busy", bus.o_busy, 1'b0);
    nxt();
    chk("to_flag_pulse", bus.o_timeout, 1'b0);
    pulse_drive(3'b001);
    nxt();
    chk("tie_grant", bus.o_grant_id, 2'd0);
    nxt(10);
    bus.i_freeNext = 1'b1;
    nxt();
    bus.i_freeNext = 1'b0;
    chk("tie_free", bus.o_free, 3'b001);
    chk("tie_no_timeout", bus.o_timeout, 1'b0);
    nxt();
    chk("tie_no_timeout2", bus.o_timeout, 1'b0);

    // spurious free, then reset during WAIT
    do_reset();
    chk("spur_clear", bus.o_spurious, 1'b0);
    bus.i_freeNext = 1'b1;
    nxt();
    bus.i_freeNext = 1'b0;
    chk("spur_set", bus.o_spurious, 1'b1);
    chk("spur_no_free", bus.o_free, 3'b000);
    nxt();
    chk("spur_no_issue", bus.o_driveNext, 1'b0);
    pulse_drive(3'b010);
    nxt();
    chk("abort_grant", bus.o_grant_id, 2'd1);
    nxt(2);
    chk("abort_wait", bus.o_busy, 1'b1);
    rst = 1'b1;
    #1;
    chk("abort_busy", bus.o_busy, 1'b0);
    chk("abort_grant0", bus.o_grant_id, 2'd0);
    chk("abort_free", bus.o_free, 3'b000);
    chk("abort_spur", bus.o_spurious, 1'b0);
    nxt(2);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      nxt();
      chk("abort_no_free", bus.o_free, 3'b000);
      chk("abort_idle", bus.o_busy, 1'b0);
    end
    pulse_drive(3'b101);
    nxt();
    serve(2'd0, 3'b001);
    serve(2'd2, 3'b100);
    chk("abort_no_stale", bus.o_driveNext, 1'b0);

`ifdef MMU_SCHED_JOIN_EN
    do_reset();
    bus.i_join = 1'b1;
    pulse_drive(3'b100);
    pulse_drive(3'b001);
    chk("join_wait_a", bus.o_driveNext, 1'b0);
    pulse_drive(3'b010);
    chk("join_wait_b", bus.o_driveNext, 1'b0);
    nxt();
    serve(2'd0, 3'b111);
    chk("join_single_issue", bus.o_driveNext, 1'b0);
    nxt();
    chk("join_single_issue2", bus.o_driveNext, 1'b0);
    bus.i_join = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
